// File: rtl/conv2_sched.sv
// conv2_sched: tracks the input raster and issues OUT_CH shared-MAC cycles per complete window.
// Results appear 1 cycle after calc_en; ready_in drops for OUT_CH cycles after each window pixel.
module conv2_sched #(
    parameter int WIDTH       = 12,
    parameter int HEIGHT      = 12,
    parameter int FILTER_SIZE = 5,
    parameter int OUT_CH      = 3,
    localparam int MAX_DIM    = (WIDTH > HEIGHT) ? WIDTH : HEIGHT,
    localparam int CW         = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
    localparam int CHW        = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_in,
    output logic           ready_in,
    output logic           calc_en,
    output logic [CHW-1:0] ch_sel,
    output logic           valid_out,
    output logic [CHW-1:0] out_ch,
    output logic [CW-1:0]  out_row,
    output logic [CW-1:0]  out_col,
    output logic           frame_done
);

    localparam logic [CW-1:0]  COL_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ROW_LAST = CW'(HEIGHT - 1);
    localparam logic [CW-1:0]  K_M1     = CW'(FILTER_SIZE - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(OUT_CH - 1);

    typedef enum logic {
        S_ACCEPT = 1'b0,
        S_ISSUE  = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   row;
    logic [CW-1:0]   col;
    logic [CHW-1:0]  ch;
    logic [CW-1:0]   win_row;
    logic [CW-1:0]   win_col;
    logic            last_win;
    logic            window_hit;

    assign window_hit = (row >= K_M1) && (col >= K_M1);

    // Handshake and datapath enables depend only on registered state.
    assign ready_in   = (state == S_ACCEPT);
    assign calc_en    = (state == S_ISSUE);
    assign ch_sel     = ch;
    assign frame_done = valid_out && (out_ch == CH_LAST) && last_win;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_ACCEPT;
            row       <= '0;
            col       <= '0;
            ch        <= '0;
            win_row   <= '0;
            win_col   <= '0;
            last_win  <= 1'b0;
            valid_out <= 1'b0;
            out_ch    <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            valid_out <= calc_en;
            out_ch    <= ch_sel;
            out_row   <= win_row;
            out_col   <= win_col;

            if (frame_done) begin
                last_win <= 1'b0;
            end

            case (state)
                S_ACCEPT: begin
                    if (valid_in) begin
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= (row == ROW_LAST) ? '0 : row + CW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (window_hit) begin
                            win_row <= row - K_M1;
                            win_col <= col - K_M1;
                            ch      <= '0;
                            state   <= S_ISSUE;
                            // Bottom-right window is the final one of the frame.
                            if (row == ROW_LAST && col == COL_LAST) begin
                                last_win <= 1'b1;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (ch == CH_LAST) begin
                        ch    <= '0;
                        state <= S_ACCEPT;
                    end else begin
                        ch <= ch + CHW'(1);
                    end
                end
                default: state <= S_ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_conv2_sched.sv
// Randomized bench for conv2_sched against a pixel-index/window-list reference model.
module tb_conv2_sched;

    localparam int W   = 12;
    localparam int H   = 12;
    localparam int FS  = 5;
    localparam int OC  = 3;
    localparam int CW  = 4;
    localparam int CHW = 2;
    localparam int NPIX = W * H;
    localparam int NRES = (W - FS + 1) * (H - FS + 1) * OC;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           valid_in = 1'b0;
    logic           ready_in;
    logic           calc_en;
    logic [CHW-1:0] ch_sel;
    logic           valid_out;
    logic [CHW-1:0] out_ch;
    logic [CW-1:0]  out_row;
    logic [CW-1:0]  out_col;
    logic           frame_done;

    conv2_sched #(.WIDTH(W), .HEIGHT(H), .FILTER_SIZE(FS), .OUT_CH(OC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .calc_en    (calc_en),
        .ch_sel     (ch_sel),
        .valid_out  (valid_out),
        .out_ch     (out_ch),
        .out_row    (out_row),
        .out_col    (out_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pixel index within the frame, remaining issue cycles,
    // and the expected ordered result list (channel, window row, window col).
    int pix     = 0;
    int busy    = 0;
    bit exp_vo  = 1'b0;
    int n_acc   = 0;
    int dut_res = 0;
    int dut_done = 0;
    int q_ch[$];
    int q_row[$];
    int q_col[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r <= H - FS; r++)
            for (int c = 0; c <= W - FS; c++)
                for (int k = 0; k < OC; k++) begin
                    q_ch.push_back(k);
                    q_row.push_back(r);
                    q_col.push_back(c);
                end
    endtask

    task automatic model_reset();
        pix = 0; busy = 0; exp_vo = 1'b0; n_acc = 0;
        dut_res = 0; dut_done = 0;
        q_ch.delete(); q_row.delete(); q_col.delete();
    endtask

    // Called at a negedge: check outputs, drive valid_in, advance the model one cycle.
    task automatic cycle(input logic v);
        int  ec, er, ecol, r, c;
        bit  last, acc;
        chk("ready_in", int'(ready_in), int'(busy == 0));
        chk("calc_en", int'(calc_en), int'(busy > 0));
        chk("ch_sel", int'(ch_sel), (busy > 0) ? OC - busy : 0);
        chk("valid_out", int'(valid_out), int'(exp_vo));
        if (valid_out) dut_res++;
        if (frame_done) dut_done++;
        if (exp_vo) begin
            if (q_ch.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                ec = q_ch.pop_front();
                er = q_row.pop_front();
                ecol = q_col.pop_front();
                last = (ec == OC - 1) && (er == H - FS) && (ecol == W - FS);
                chk("out_ch", int'(out_ch), ec);
                chk("out_row", int'(out_row), er);
                chk("out_col", int'(out_col), ecol);
                chk("frame_done", int'(frame_done), int'(last));
            end
        end else begin
            chk("frame_done_idle", int'(frame_done), 0);
        end

        valid_in = v;
        acc = v && (busy == 0);
        exp_vo = (busy > 0);
        if (busy > 0) busy--;
        if (acc) begin
            if (pix == 0) push_frame();
            r = pix / W;
            c = pix % W;
            if (r >= FS - 1 && c >= FS - 1) busy = OC;
            pix = (pix + 1) % NPIX;
            n_acc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        valid_in = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_in", int'(ready_in), 1);
        chk("rst_calc_en", int'(calc_en), 0);
        chk("rst_ch_sel", int'(ch_sel), 0);
        chk("rst_valid_out", int'(valid_out), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_out_row", int'(out_row), 0);
        chk("rst_out_col", int'(out_col), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        model_reset();
        rst_n = 1'b1;
    endtask

    // duty: percent chance valid_in is high in a given cycle.
    task automatic run_frames(input int nframes, input int duty, input string tag);
        int cyc = 0;
        while (n_acc < nframes * NPIX && cyc < 20000) begin
            cycle($urandom_range(99, 0) < duty);
            cyc++;
        end
        if (cyc >= 20000) chk({tag, "_timeout"}, cyc, -1);
        repeat (OC + 3) cycle(1'b0);
        chk({tag, "_accepts"}, n_acc, nframes * NPIX);
        chk({tag, "_results"}, dut_res, nframes * NRES);
        chk({tag, "_frame_done"}, dut_done, nframes);
        chk({tag, "_sb_empty"}, q_ch.size(), 0);
    endtask

    initial begin
        @(negedge clk);
        do_reset(3);

        run_frames(1, 100, "cont");
        run_frames(1, 50, "gaps");

        // Abort a channel sequence mid-way, then two back-to-back frames.
        model_reset();
        for (int i = 0; i < 200 && busy != OC - 1; i++) cycle(1'b1);
        chk("mid_ch_sel", int'(ch_sel), 1);
        do_reset(1);
        chk("post_rst_calc_en", int'(calc_en), 0);
        chk("post_rst_ready_in", int'(ready_in), 1);
        run_frames(2, 100, "b2b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
